// File: rtl/mipi_pkg.sv
// Shared CSI-2 receive definitions: HS sync pattern, lane FSM encoding, data type codes
// and the sync-window search used by the lane aligner.
package mipi_pkg;

  localparam logic [7:0] HS_SYNC_BYTE = 8'hB8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StHunt   = 2'd1,
    StLocked = 2'd2
  } lane_state_e;

  typedef enum logic [5:0] {
    DtFrameStart = 6'h00,
    DtFrameEnd   = 6'h01,
    DtLineStart  = 6'h02,
    DtLineEnd    = 6'h03,
    DtYuv422_8   = 6'h1E,
    DtRgb565     = 6'h22,
    DtRgb888     = 6'h24,
    DtRaw8       = 6'h2A,
    DtRaw10      = 6'h2B,
    DtRaw12      = 6'h2C
  } csi2_dt_e;

  typedef struct packed {
    logic       found;
    logic [1:0] offset;
  } sync_hit_t;

  // Scan high to low so the lowest matching bit offset is the one reported.
  function automatic sync_hit_t find_sync(input logic [15:0] sr, input logic [7:0] pattern);
    sync_hit_t hit;
    hit.found  = 1'b0;
    hit.offset = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (sr[k +: 8] == pattern) begin
        hit.found  = 1'b1;
        hit.offset = 2'(k);
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/mipi_lane_sync.sv
// One HS lane: nibble shift register, sync hunt at any bit offset, byte extraction at the
// locked offset and a small byte FIFO for deskew.
module mipi_lane_sync
  import mipi_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = HS_SYNC_BYTE,
  parameter int unsigned HUNT_TIMEOUT = 64,
  parameter int unsigned DEPTH        = 4
) (
  input  logic       sync_mipi_clk_2,
  input  logic       reset,
  input  logic       stop,
  input  logic [3:0] nib,
  input  logic       pop,
  output logic       locked,
  output logic       lock_pulse,
  output logic       timeout_pulse,
  output logic       not_empty,
  output logic [7:0] head
);

  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned HuntW = $clog2(HUNT_TIMEOUT + 1);
  localparam logic [PtrW-1:0]  LastPtr  = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0]  FullCnt  = CntW'(DEPTH);
  localparam logic [HuntW-1:0] HuntMax  = HuntW'(HUNT_TIMEOUT);
  localparam logic [HuntW-1:0] HuntLast = HuntW'(HUNT_TIMEOUT - 1);

  lane_state_e      state;
  logic [15:0]      sr;
  logic [1:0]       offset;
  logic             phase;
  logic [HuntW-1:0] hunt_cnt;
  logic [7:0]       mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;

  sync_hit_t hit;
  logic [7:0] cur_byte;
  logic       push;
  logic       do_push;
  logic       do_pop;

  always_comb begin
    hit           = find_sync(sr, SYNC_BYTE);
    cur_byte      = sr[offset +: 8];
    // phase is 1 on every second LOCKED cycle, when a whole new byte sits at the offset
    push          = (state == StLocked) && phase && !stop;
    do_pop        = pop && (count != '0) && !stop;
    // a full FIFO only accepts a write when the same cycle frees a slot
    do_push       = push && ((count != FullCnt) || do_pop);
    lock_pulse    = (state == StHunt) && hit.found && !stop;
    timeout_pulse = (state == StHunt) && !hit.found && (hunt_cnt == HuntLast) && !stop;
  end

  assign locked    = (state == StLocked);
  assign not_empty = (count != '0);
  assign head      = mem[rd_ptr];

  always_ff @(posedge sync_mipi_clk_2) begin
    if (reset || stop) begin
      state    <= StIdle;
      sr       <= '0;
      offset   <= '0;
      phase    <= 1'b0;
      hunt_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      sr <= {nib, sr[15:4]};

      case (state)
        StIdle: state <= StHunt;
        StHunt: begin
          if (hit.found) begin
            state  <= StLocked;
            offset <= hit.offset;
            phase  <= 1'b0;
          end else if (hunt_cnt != HuntMax) begin
            hunt_cnt <= hunt_cnt + HuntW'(1);
          end
        end
        StLocked: phase <= ~phase;
        default:  state <= StIdle;
      endcase

      if (do_push) begin
        mem[wr_ptr] <= cur_byte;
        wr_ptr      <= (wr_ptr == LastPtr) ? '0 : wr_ptr + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + PtrW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CntW'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/mipi_hs_lane_aligner.sv
// Two-lane HS aligner: per-lane sync search and byte FIFOs, inter-lane skew supervision and
// a registered lane-aligned byte pair output.
module mipi_hs_lane_aligner
  import mipi_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = HS_SYNC_BYTE,
  parameter int unsigned HUNT_TIMEOUT = 64,
  parameter int unsigned MAX_SKEW     = 2
) (
  input  logic       sync_mipi_clk_2,
  input  logic       reset,
  input  logic       stop,
  input  logic [3:0] lane0_nib,
  input  logic [3:0] lane1_nib,
  output logic [7:0] byte0_o,
  output logic [7:0] byte1_o,
  output logic       valid_o,
  output logic       sync_o,
  output logic       err_timeout_o,
  output logic       err_skew_o
);

  localparam int unsigned FifoDepth = MAX_SKEW + 2;
  localparam int unsigned SkewLimit = 2 * MAX_SKEW;
  localparam int unsigned SkewW     = $clog2(SkewLimit + 2);
  localparam logic [SkewW-1:0] SkewMax = SkewW'(SkewLimit);

  logic       locked0, locked1;
  logic       lock_pulse0, lock_pulse1;
  logic       timeout0, timeout1;
  logic       not_empty0, not_empty1;
  logic [7:0] head0, head1;
  logic       pop;
  logic       waiting;
  logic       skew_over;
  logic [SkewW-1:0] skew_cnt;

  mipi_lane_sync #(
    .SYNC_BYTE    (SYNC_BYTE),
    .HUNT_TIMEOUT (HUNT_TIMEOUT),
    .DEPTH        (FifoDepth)
  ) u_lane0 (
    .sync_mipi_clk_2 (sync_mipi_clk_2),
    .reset           (reset),
    .stop            (stop),
    .nib             (lane0_nib),
    .pop             (pop),
    .locked          (locked0),
    .lock_pulse      (lock_pulse0),
    .timeout_pulse   (timeout0),
    .not_empty       (not_empty0),
    .head            (head0)
  );

  mipi_lane_sync #(
    .SYNC_BYTE    (SYNC_BYTE),
    .HUNT_TIMEOUT (HUNT_TIMEOUT),
    .DEPTH        (FifoDepth)
  ) u_lane1 (
    .sync_mipi_clk_2 (sync_mipi_clk_2),
    .reset           (reset),
    .stop            (stop),
    .nib             (lane1_nib),
    .pop             (pop),
    .locked          (locked1),
    .lock_pulse      (lock_pulse1),
    .timeout_pulse   (timeout1),
    .not_empty       (not_empty1),
    .head            (head1)
  );

  // skew_cnt counts cycles with exactly one lane locked; the lock pulses are not needed
  // because the later lane's locked flag ends the wait the cycle after its pulse.
  always_comb begin
    waiting   = locked0 ^ locked1;
    skew_over = waiting && (skew_cnt == SkewMax) && !stop;
    pop       = not_empty0 && not_empty1 && !err_skew_o && !stop;
  end

  always_ff @(posedge sync_mipi_clk_2) begin
    if (reset) begin
      byte0_o       <= '0;
      byte1_o       <= '0;
      valid_o       <= 1'b0;
      sync_o        <= 1'b0;
      err_timeout_o <= 1'b0;
      err_skew_o    <= 1'b0;
      skew_cnt      <= '0;
    end else begin
      if (timeout0 || timeout1) begin
        err_timeout_o <= 1'b1;
      end
      if (skew_over) begin
        err_skew_o <= 1'b1;
      end
      if (stop) begin
        byte0_o  <= '0;
        byte1_o  <= '0;
        valid_o  <= 1'b0;
        sync_o   <= 1'b0;
        skew_cnt <= '0;
      end else begin
        valid_o  <= pop;
        skew_cnt <= !waiting ? '0 : (skew_cnt == SkewMax) ? skew_cnt : skew_cnt + SkewW'(1);
        if (pop) begin
          byte0_o <= head0;
          byte1_o <= head1;
          sync_o  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mipi_hs_lane_aligner.sv
// Directed bench for mipi_hs_lane_aligner: per-lane bit streams feed the nibbles, expected
// byte pairs go to a scoreboard queue and a negedge monitor checks every valid_o strobe.
module tb_mipi_hs_lane_aligner;

  logic       clk;
  logic       reset;
  logic       stop;
  logic [3:0] lane0_nib;
  logic [3:0] lane1_nib;
  logic [7:0] byte0_o;
  logic [7:0] byte1_o;
  logic       valid_o;
  logic       sync_o;
  logic       err_timeout_o;
  logic       err_skew_o;

  mipi_hs_lane_aligner #(
    .SYNC_BYTE    (8'hB8),
    .HUNT_TIMEOUT (64),
    .MAX_SKEW     (2)
  ) dut (
    .sync_mipi_clk_2 (clk),
    .reset           (reset),
    .stop            (stop),
    .lane0_nib       (lane0_nib),
    .lane1_nib       (lane1_nib),
    .byte0_o         (byte0_o),
    .byte1_o         (byte1_o),
    .valid_o         (valid_o),
    .sync_o          (sync_o),
    .err_timeout_o   (err_timeout_o),
    .err_skew_o      (err_skew_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int first_cyc = -1;

  logic        q0[$];
  logic        q1[$];
  logic [15:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every strobe must be expected and must carry the next scoreboard pair.
  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      if (first_cyc < 0) first_cyc = cyc;
      check("valid_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() != 0) begin
        check("byte_pair", {byte0_o, byte1_o}, exp_q.pop_front());
      end
    end
  end

  task automatic add_zeros(input int lane, input int n);
    for (int i = 0; i < n; i++) begin
      if (lane == 0) q0.push_back(1'b0);
      else q1.push_back(1'b0);
    end
  endtask

  task automatic add_byte(input int lane, input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      if (lane == 0) q0.push_back(b[i]);
      else q1.push_back(b[i]);
    end
  endtask

  task automatic add_pair(input logic [7:0] b0, input logic [7:0] b1);
    add_byte(0, b0);
    add_byte(1, b1);
    exp_q.push_back({b0, b1});
  endtask

  task automatic add_sync();
    add_byte(0, 8'hB8);
    add_byte(1, 8'hB8);
  endtask

  // Drive the next nibble of each lane (earliest bit in bit0), then step one edge.
  task automatic tick();
    logic [3:0] n0;
    logic [3:0] n1;
    for (int b = 0; b < 4; b++) begin
      n0[b] = (q0.size() > 0) ? q0.pop_front() : 1'b0;
      n1[b] = (q1.size() > 0) ? q1.pop_front() : 1'b0;
    end
    lane0_nib = n0;
    lane1_nib = n1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stop  = 1'b1;
    q0.delete();
    q1.delete();
    exp_q.delete();
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  // Burst edge j is the j-th edge with stop low (j from 0). With the sync byte starting at
  // stream bit s, lock registers at edge s/4+4 and the first pair appears after edge s/4+7,
  // counted for the later lane. A burst with expected pairs ends by raising stop exactly on
  // the edge that would carry the next (unexpected) pair.
  task automatic run_burst(input string name, input int ticks, input int exp_first);
    int base;
    int i;
    stop = 1'b0;
    base = cyc + 1;
    first_cyc = -1;
    if (exp_q.size() != 0) begin
      i = 0;
      while (exp_q.size() != 0 && i < ticks) begin
        tick();
        i++;
      end
      check({name, "_drained"}, exp_q.size(), 0);
      check({name, "_first_valid_edge"}, first_cyc - base, exp_first);
      check({name, "_sync_o"}, sync_o, 1'b1);
      stop = 1'b1;
      q0.delete();
      q1.delete();
      exp_q.delete();
      tick();
      check({name, "_valid_after_stop"}, valid_o, 1'b0);
      check({name, "_sync_after_stop"}, sync_o, 1'b0);
    end else begin
      for (int j = 0; j < ticks; j++) tick();
      stop = 1'b1;
      q0.delete();
      q1.delete();
      tick();
    end
    tick();
  endtask

  initial begin
    reset     = 1'b1;
    stop      = 1'b1;
    lane0_nib = 4'h0;
    lane1_nib = 4'h0;
    do_reset();
    check("reset_valid", valid_o, 1'b0);
    check("reset_sync", sync_o, 1'b0);
    check("reset_byte0", byte0_o, 8'h00);
    check("reset_byte1", byte1_o, 8'h00);
    check("reset_err_timeout", err_timeout_o, 1'b0);
    check("reset_err_skew", err_skew_o, 1'b0);

    // Zero skew, both lanes at k=0.
    add_sync();
    add_pair(8'h12, 8'h56);
    add_pair(8'h34, 8'h78);
    run_burst("zero_skew", 40, 7);

    // Lane0 k=3 behind a 0xB9 decoy, lane1 k=1; both syncs start at stream bit 16+.
    add_zeros(0, 3);
    add_byte(0, 8'hB9);
    add_zeros(0, 8);
    add_zeros(1, 17);
    add_sync();
    add_pair(8'h12, 8'h56);
    add_pair(8'h34, 8'h78);
    run_burst("bit_offset", 40, 11);

    // Lane1 one byte (2 cycles) late.
    add_byte(0, 8'hB8);
    add_zeros(1, 8);
    add_byte(1, 8'hB8);
    add_pair(8'hA1, 8'hB1);
    add_pair(8'hA2, 8'hB2);
    add_pair(8'hA3, 8'hB3);
    run_burst("skew_1byte", 40, 9);
    check("skew_1byte_no_err", err_skew_o, 1'b0);

    // Lane1 four cycles late: the largest skew still absorbed.
    add_byte(0, 8'hB8);
    add_zeros(1, 16);
    add_byte(1, 8'hB8);
    add_pair(8'hC1, 8'hD1);
    add_pair(8'hC2, 8'hD2);
    run_burst("skew_limit", 40, 11);
    check("skew_limit_no_err", err_skew_o, 1'b0);

    // Lane1 six cycles late: skew error, no output, next burst blocked too.
    add_byte(0, 8'hB8);
    add_byte(0, 8'h11);
    add_byte(0, 8'h22);
    add_zeros(1, 24);
    add_byte(1, 8'hB8);
    add_byte(1, 8'h33);
    run_burst("skew_over", 30, -1);
    check("skew_over_err", err_skew_o, 1'b1);
    check("skew_over_sync", sync_o, 1'b0);
    add_sync();
    add_byte(0, 8'h44);
    add_byte(1, 8'h55);
    run_burst("skew_blocked", 20, -1);
    check("skew_blocked_err_sticky", err_skew_o, 1'b1);
    do_reset();
    check("skew_err_cleared_by_reset", err_skew_o, 1'b0);

    // Hunt timeout on all-zero data.
    stop = 1'b0;
    for (int j = 0; j < 70; j++) begin
      tick();
      if (j == 63) check("timeout_edge63", err_timeout_o, 1'b0);
      if (j == 64) check("timeout_edge64", err_timeout_o, 1'b1);
    end
    stop = 1'b1;
    tick();
    tick();
    check("timeout_sticky", err_timeout_o, 1'b1);
    check("timeout_no_skew", err_skew_o, 1'b0);
    do_reset();
    check("timeout_cleared_by_reset", err_timeout_o, 1'b0);

    // Stop after three pairs while more data is in flight, then a fresh burst.
    add_sync();
    add_pair(8'h01, 8'h81);
    add_pair(8'h02, 8'h82);
    add_pair(8'h03, 8'h83);
    add_byte(0, 8'h04);
    add_byte(1, 8'h84);
    add_byte(0, 8'h05);
    add_byte(1, 8'h85);
    run_burst("stop_mid", 40, 7);
    add_zeros(0, 2);
    add_zeros(1, 3);
    add_sync();
    add_pair(8'h5A, 8'hA5);
    add_pair(8'h3C, 8'hC3);
    run_burst("restart", 40, 7);
    check("restart_no_err", {err_timeout_o, err_skew_o}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
